seq_divider: RTL and testbench

//  Parametrised multi-cycle integer divider: restoring shift/subtract, one quotient bit per enabled clock.

---
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring (shift/subtract) integer divider.
// Produces one quotient bit per enabled clock, with a START/BUSY/DONE handshake,
// a remainder output and divide-by-zero detection.
// Optional macro DIVIDER_SIGNED_EN adds the SGN input and two's-complement operation.

module seq_divider #(
  parameter int C_NUM_BITS = 8
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  E,
  input  logic                  START,
`ifdef DIVIDER_SIGNED_EN
  input  logic                  SGN,
`endif
  input  logic [C_NUM_BITS-1:0] A,
  input  logic [C_NUM_BITS-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [C_NUM_BITS-1:0] Q,
  output logic [C_NUM_BITS-1:0] REM,
  output logic                  DZ
);

  localparam int N  = C_NUM_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_next;
  logic [N-1:0]  dvd_reg, dvd_next;
  logic [N-1:0]  dvs_reg, dvs_next;
  logic [N-1:0]  part_reg, part_next;
  logic [CW-1:0] count, count_next;
  logic [N-1:0]  q_reg, q_next;
  logic [N-1:0]  rem_reg, rem_next;
  logic          dz_reg, dz_next;

  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    shifted, trial;
  logic [N-1:0]  step_q, step_part;
  logic [N-1:0]  fin_q, fin_rem;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic neg_q_in, neg_r_in;

  // Signed requests feed operand magnitudes to the unsigned core and remember the result signs.
  always_comb begin
    a_mag    = (SGN && A[N-1]) ? -A : A;
    b_mag    = (SGN && B[N-1]) ? -B : B;
    neg_q_in = SGN && (A[N-1] ^ B[N-1]);
    neg_r_in = SGN && A[N-1];
  end

  // Final sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    fin_q   = neg_q_reg ? -step_q : step_q;
    fin_rem = neg_r_reg ? -step_part : step_part;
  end

  // Result-sign flags captured alongside the operands.
  always_ff @(posedge CK) begin
    if (R) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (E) begin
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    a_mag   = A;
    b_mag   = B;
    fin_q   = step_q;
    fin_rem = step_part;
  end
`endif

  // One restoring step: bring in the next dividend bit and try to subtract the divisor.
  always_comb begin
    shifted = {part_reg, dvd_reg[N-1]};
    trial   = shifted - {1'b0, dvs_reg};
    if (!trial[N]) begin
      step_part = trial[N-1:0];
      step_q    = {dvd_reg[N-2:0], 1'b1};
    end else begin
      step_part = shifted[N-1:0];
      step_q    = {dvd_reg[N-2:0], 1'b0};
    end
  end

  // Next-state and datapath-load decisions for the IDLE/RUN/FIN controller.
  always_comb begin
    state_next = state;
    dvd_next   = dvd_reg;
    dvs_next   = dvs_reg;
    part_next  = part_reg;
    count_next = count;
    q_next     = q_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
`ifdef DIVIDER_SIGNED_EN
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
`endif
    case (state)
      IDLE, FIN: begin
        if (START) begin
          if (B == '0) begin
            state_next = FIN;
            q_next     = '1;
            rem_next   = A;
            dz_next    = 1'b1;
          end else begin
            state_next = RUN;
            dvd_next   = a_mag;
            dvs_next   = b_mag;
            part_next  = '0;
            count_next = LAST_COUNT;
`ifdef DIVIDER_SIGNED_EN
            neg_q_next = neg_q_in;
            neg_r_next = neg_r_in;
`endif
          end
        end else if (state == FIN) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        dvd_next  = step_q;
        part_next = step_part;
        if (count == '0) begin
          state_next = FIN;
          q_next     = fin_q;
          rem_next   = fin_rem;
          dz_next    = 1'b0;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers: reset wins over enable, E=0 freezes everything.
  always_ff @(posedge CK) begin
    if (R) begin
      state    <= IDLE;
      dvd_reg  <= '0;
      dvs_reg  <= '0;
      part_reg <= '0;
      count    <= '0;
      q_reg    <= '0;
      rem_reg  <= '0;
      dz_reg   <= 1'b0;
    end else if (E) begin
      state    <= state_next;
      dvd_reg  <= dvd_next;
      dvs_reg  <= dvs_next;
      part_reg <= part_next;
      count    <= count_next;
      q_reg    <= q_next;
      rem_reg  <= rem_next;
      dz_reg   <= dz_next;
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);
  assign Q    = q_reg;
  assign REM  = rem_reg;
  assign DZ   = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (C_NUM_BITS = 8).
// A cycle-level behavioural model predicts BUSY/DONE/Q/REM/DZ from plain
// arithmetic; directed tests add hand-computed literal expectations.

module tb_seq_divider;

  localparam int N = 8;

  logic         CK = 1'b0;
  logic         R = 1'b1;
  logic         E = 1'b1;
  logic         START = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
`ifdef DIVIDER_SIGNED_EN
  logic         SGN = 1'b0;
`endif
  logic         BUSY, DONE, DZ;
  logic [N-1:0] Q, REM;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  seq_divider #(.C_NUM_BITS(N)) dut (
    .CK(CK),
    .R(R),
    .E(E),
    .START(START),
`ifdef DIVIDER_SIGNED_EN
    .SGN(SGN),
`endif
    .A(A),
    .B(B),
    .BUSY(BUSY),
    .DONE(DONE),
    .Q(Q),
    .REM(REM),
    .DZ(DZ)
  );

  // Free-running clock
  always #5 CK = ~CK;

  // Model state
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_dz = 1'b0;
  logic [N-1:0] m_q = '0;
  logic [N-1:0] m_rem = '0;
  logic [N-1:0] pend_q = '0;
  logic [N-1:0] pend_rem = '0;
  int           m_left = 0;
  int           sa, sb;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: a division takes N enabled edges after acceptance, results from / and %
  always @(posedge CK) begin
    cyc++;
    if (R) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_q    = '0;
      m_rem  = '0;
      m_left = 0;
    end else if (E) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q    = pend_q;
          m_rem  = pend_rem;
          m_dz   = 1'b0;
        end
      end else if (START) begin
        if (B == 0) begin
          m_done = 1'b1;
          m_q    = '1;
          m_rem  = A;
          m_dz   = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_left = N;
`ifdef DIVIDER_SIGNED_EN
          if (SGN) begin
            sa = int'($signed(A));
            sb = int'($signed(B));
            if (sa == -(2 ** (N - 1)) && sb == -1) begin
              pend_q   = {1'b1, {(N-1){1'b0}}};
              pend_rem = '0;
            end else begin
              pend_q   = N'(sa / sb);
              pend_rem = N'(sa % sb);
            end
          end else
`endif
          begin
            pend_q   = A / B;
            pend_rem = A % B;
          end
        end
      end
    end
  end

  // Compare process: every cycle after reset, away from the active edge
  always @(negedge CK) begin
    if (check_en) begin
      checkOutput("busy", BUSY, m_busy);
      checkOutput("done", DONE, m_done);
      checkOutput("q", Q, m_q);
      checkOutput("rem", REM, m_rem);
      checkOutput("dz", DZ, m_dz);
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Issue one division, optionally dropping E for stall_len cycles, and return cycles to DONE
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input int stall_at, input int stall_len, output int lat);
    A = a;
    B = b;
    START = 1'b1;
    tick();
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 60) begin
      tick();
      lat++;
      E = !(lat >= stall_at && lat < stall_at + stall_len);
    end
    E = 1'b1;
    if (!DONE) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Safety net against a hung DUT
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int lat;
  bit seen_done;
  int va[8] = '{0, 255, 1, 254, 128, 0, 255, 77};
  int vb[8] = '{1, 1, 255, 255, 128, 5, 2, 13};
  logic [N-1:0] ra, rb;

  // Directed test sequence
  initial begin
    repeat (2) @(posedge CK);
    #1;
    R = 1'b0;
    check_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_busy", BUSY, 1'b0);
    checkOutput("rst_done", DONE, 1'b0);
    checkOutput("rst_q", Q, 8'h00);
    checkOutput("rst_rem", REM, 8'h00);
    checkOutput("rst_dz", DZ, 1'b0);

    $display("[TB] test 1: 100 / 7");
    applyStimulus(8'd100, 8'd7, 0, 0, lat);
    checkOutput("t1_lat", lat, 9);
    checkOutput("t1_q", Q, 8'd14);
    checkOutput("t1_rem", REM, 8'd2);
    checkOutput("t1_dz", DZ, 1'b0);
    tick();
    tick();

    $display("[TB] test 2: 5 / 0");
    applyStimulus(8'd5, 8'd0, 0, 0, lat);
    checkOutput("t2_lat", lat, 1);
    checkOutput("t2_q", Q, 8'hFF);
    checkOutput("t2_rem", REM, 8'd5);
    checkOutput("t2_dz", DZ, 1'b1);
    tick();
    tick();

    $display("[TB] test 3: ignored STARTs and back-to-back");
    A = 8'd200;
    B = 8'd3;
    START = 1'b1;
    tick();
    A = 8'd9;
    B = 8'd2;
    lat = 1;
    while (!DONE && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput("t3a_lat", lat, 9);
    checkOutput("t3a_q", Q, 8'd66);
    checkOutput("t3a_rem", REM, 8'd2);
    A = 8'd255;
    B = 8'd255;
    tick();
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput("t3b_lat", lat, 9);
    checkOutput("t3b_q", Q, 8'd1);
    checkOutput("t3b_rem", REM, 8'd0);
    tick();
    tick();

    $display("[TB] test 4: enable stall and reset abort");
    applyStimulus(8'd100, 8'd7, 3, 3, lat);
    checkOutput("t4_lat", lat, 12);
    checkOutput("t4_q", Q, 8'd14);
    checkOutput("t4_rem", REM, 8'd2);
    tick();
    A = 8'd100;
    B = 8'd7;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    R = 1'b1;
    E = 1'b0;
    tick();
    R = 1'b0;
    E = 1'b1;
    checkOutput("t4r_busy", BUSY, 1'b0);
    checkOutput("t4r_done", DONE, 1'b0);
    checkOutput("t4r_q", Q, 8'd0);
    checkOutput("t4r_rem", REM, 8'd0);
    checkOutput("t4r_dz", DZ, 1'b0);
    seen_done = 1'b0;
    repeat (15) begin
      tick();
      seen_done |= DONE;
    end
    checkOutput("t4r_no_done", seen_done, 1'b0);

    $display("[TB] test 5: boundary and random operands");
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        ra = N'(va[i]);
        rb = N'(vb[i]);
      end else begin
        ra = N'($urandom_range(0, 255));
        rb = N'($urandom_range(1, 255));
      end
      applyStimulus(ra, rb, 0, 0, lat);
      checkOutput("t5_lat", lat, 9);
      checkOutput("t5_identity", int'(Q) * int'(rb) + int'(REM), int'(ra));
      checkOutput("t5_rem_lt_b", (REM < rb), 1'b1);
    end
    tick();

`ifdef DIVIDER_SIGNED_EN
    $display("[TB] test 6: signed mode");
    SGN = 1'b1;
    applyStimulus(8'hF9, 8'd2, 0, 0, lat);
    checkOutput("t6a_q", Q, 8'hFD);
    checkOutput("t6a_rem", REM, 8'hFF);
    tick();
    applyStimulus(8'h80, 8'hFF, 0, 0, lat);
    checkOutput("t6b_q", Q, 8'h80);
    checkOutput("t6b_rem", REM, 8'h00);
    tick();
    applyStimulus(8'h05, 8'h00, 0, 0, lat);
    checkOutput("t6c_q", Q, 8'hFF);
    checkOutput("t6c_rem", REM, 8'h05);
    checkOutput("t6c_dz", DZ, 1'b1);
    SGN = 1'b0;
    tick();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
